// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the register/ALU/immediate datapath.
// Decodes RV32I OP and OP-IMM instructions into write_en/alu_sel/alu_src_sel for one EXEC cycle.
module alu_seq_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned ALU_SEL_WIDTH = 4,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     run_en,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              instruction,
  output logic                     write_en,
  output logic [ALU_SEL_WIDTH-1:0] alu_sel,
  output logic                     alu_src_sel,
  output logic                     busy,
  output logic                     illegal,
  output logic [CNT_WIDTH-1:0]     retired_count
);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, EXEC} state_t;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  state_t      state, next_state;
  logic [31:0] pc;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        dec_legal;
  logic [3:0]  dec_sel;
  logic        dec_src;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  // Decoder runs off the instruction register every cycle; outputs are gated to EXEC below.
  always_comb begin
    dec_legal = 1'b0;
    dec_sel   = ALU_ADD;
    dec_src   = 1'b0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          case (funct3)
            3'b000:  dec_sel = ALU_ADD;
            3'b001:  dec_sel = ALU_SLL;
            3'b010:  dec_sel = ALU_SLT;
            3'b011:  dec_sel = ALU_SLTU;
            3'b100:  dec_sel = ALU_XOR;
            3'b101:  dec_sel = ALU_SRL;
            3'b110:  dec_sel = ALU_OR;
            default: dec_sel = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            dec_legal = 1'b1;
            dec_sel   = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            dec_legal = 1'b1;
            dec_sel   = ALU_SRA;
          end
        end
      end
      OPC_IMM: begin
        dec_src = 1'b1;
        case (funct3)
          3'b000: begin dec_legal = 1'b1; dec_sel = ALU_ADD;  end
          3'b010: begin dec_legal = 1'b1; dec_sel = ALU_SLT;  end
          3'b011: begin dec_legal = 1'b1; dec_sel = ALU_SLTU; end
          3'b100: begin dec_legal = 1'b1; dec_sel = ALU_XOR;  end
          3'b110: begin dec_legal = 1'b1; dec_sel = ALU_OR;   end
          3'b111: begin dec_legal = 1'b1; dec_sel = ALU_AND;  end
          3'b001: begin
            dec_legal = (funct7 == F7_BASE);
            dec_sel   = ALU_SLL;
          end
          default: begin
            if (funct7 == F7_BASE) begin
              dec_legal = 1'b1;
              dec_sel   = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              dec_legal = 1'b1;
              dec_sel   = ALU_SRA;
            end
          end
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    imem_req    = 1'b0;
    write_en    = 1'b0;
    alu_sel     = '0;
    alu_src_sel = 1'b0;
    illegal     = 1'b0;
    case (state)
      IDLE:  if (run_en) next_state = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_gnt) next_state = WAIT;
      end
      WAIT:  if (imem_rvalid) next_state = EXEC;
      default: begin
        write_en    = dec_legal;
        illegal     = !dec_legal;
        alu_sel     = dec_legal ? ALU_SEL_WIDTH'(dec_sel) : '0;
        alu_src_sel = dec_legal && dec_src;
        next_state  = run_en ? FETCH : IDLE;
      end
    endcase
  end

  assign busy      = (state != IDLE);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc            <= RESET_PC;
      instruction   <= '0;
      retired_count <= '0;
    end else begin
      if (state == WAIT && imem_rvalid) instruction <= imem_rdata;
      if (state == EXEC) begin
        pc <= pc + 32'd4;
        if (dec_legal) retired_count <= retired_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a memory responder drives the fetch handshake and
// a scoreboard queue holds the expected EXEC decode for each instruction word delivered.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        run_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        write_en;
  logic [3:0]  alu_sel;
  logic        alu_src_sel;
  logic        busy;
  logic        illegal;
  logic [31:0] retired_count;

  alu_seq_ctrl #(
    .RESET_PC      (32'h0000_0000),
    .ALU_SEL_WIDTH (4),
    .CNT_WIDTH     (32)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .run_en        (run_en),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .write_en      (write_en),
    .alu_sel       (alu_sel),
    .alu_src_sel   (alu_src_sel),
    .busy          (busy),
    .illegal       (illegal),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] sel;
    logic       src;
    logic       ill;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_pc  = 32'h0;
  logic [31:0] exp_cnt = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One full instruction: fetch handshake with configurable gnt/rvalid latency, then EXEC checks.
  task automatic do_instr(input logic [31:0] word, input logic we, input logic [3:0] sel,
                          input logic src, input int gnt_wait, input int rv_delay,
                          input logic drop_run);
    exp_t e;
    exp_t got;
    bit   found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    if (!found) return;
    check("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < gnt_wait; i++) begin
      @(negedge clk);
      check("req_hold", {31'b0, imem_req}, 32'd1);
      check("addr_hold", imem_addr, exp_pc);
    end
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("wait_req_low", {31'b0, imem_req}, 32'd0);
    if (drop_run) run_en = 1'b0;
    for (int i = 1; i < rv_delay; i++) begin
      @(negedge clk);
      check("wait_we_low", {31'b0, write_en}, 32'd0);
      check("wait_busy", {31'b0, busy}, 32'd1);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    e.we  = we;
    e.sel = sel;
    e.src = src;
    e.ill = !we;
    sb.push_back(e);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    got = sb.pop_front();
    check("exec_we", {31'b0, write_en}, {31'b0, got.we});
    check("exec_illegal", {31'b0, illegal}, {31'b0, got.ill});
    check("exec_instr", instruction, word);
    if (got.we) begin
      check("exec_alu_sel", {28'b0, alu_sel}, {28'b0, got.sel});
      check("exec_src_sel", {31'b0, alu_src_sel}, {31'b0, got.src});
      exp_cnt = exp_cnt + 32'd1;
    end
    exp_pc = exp_pc + 32'd4;
    @(negedge clk);
    check("post_we", {31'b0, write_en}, 32'd0);
    check("post_illegal", {31'b0, illegal}, 32'd0);
    check("retired", retired_count, exp_cnt);
    if (drop_run) begin
      check("stop_busy", {31'b0, busy}, 32'd0);
      check("stop_req", {31'b0, imem_req}, 32'd0);
      repeat (3) @(negedge clk);
      check("stop_req_stays", {31'b0, imem_req}, 32'd0);
      check("stop_addr", imem_addr, exp_pc);
    end else begin
      check("next_req", {31'b0, imem_req}, 32'd1);
      check("next_addr", imem_addr, exp_pc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rstn        = 1'b0;
    run_en      = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_we", {31'b0, write_en}, 32'd0);
    check("rst_alu_sel", {28'b0, alu_sel}, 32'd0);
    check("rst_src", {31'b0, alu_src_sel}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_count", retired_count, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // word,        we,  sel,   src,  gnt_wait, rv_delay, drop_run
    do_instr(32'h00208033, 1'b1, 4'd0, 1'b0, 0, 1, 1'b0); // add x0,x1,x2
    do_instr(32'h4030D093, 1'b1, 4'd7, 1'b1, 0, 1, 1'b0); // srai x1,x1,3
    do_instr(32'h4020F0B3, 1'b0, 4'd0, 1'b0, 0, 1, 1'b0); // funct7 alt with and: illegal
    do_instr(32'h40208033, 1'b1, 4'd1, 1'b0, 0, 1, 1'b0); // sub
    do_instr(32'h0050F093, 1'b1, 4'd2, 1'b1, 0, 1, 1'b0); // andi
    do_instr(32'h40109093, 1'b0, 4'd0, 1'b0, 0, 1, 1'b0); // slli with funct7 alt: illegal
    do_instr(32'h0020B033, 1'b1, 4'd9, 1'b0, 0, 1, 1'b0); // sltu
    do_instr(32'h000010B7, 1'b0, 4'd0, 1'b0, 0, 1, 1'b0); // lui: unsupported opcode
    do_instr(32'h0020E2B3, 1'b1, 4'd3, 1'b0, 5, 3, 1'b0); // or x5, slow gnt and rvalid
    do_instr(32'h0020D033, 1'b1, 4'd6, 1'b0, 0, 1, 1'b0); // srl
    do_instr(32'h4020D033, 1'b1, 4'd7, 1'b0, 0, 1, 1'b0); // sra
    do_instr(32'h0050C093, 1'b1, 4'd4, 1'b1, 0, 1, 1'b0); // xori
    do_instr(32'h0050A093, 1'b1, 4'd8, 1'b1, 1, 2, 1'b0); // slti
    do_instr(32'h00209033, 1'b1, 4'd5, 1'b0, 0, 1, 1'b1); // sll, run_en dropped in WAIT

    // rvalid while idle must not touch the instruction register
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEADBEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    @(negedge clk);
    check("idle_rvalid_instr", instruction, 32'h00209033);
    check("idle_rvalid_busy", {31'b0, busy}, 32'd0);

    // Reset while waiting for read data; the late rvalid must be ignored.
    run_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) break;
      @(negedge clk);
    end
    check("rw_req", {31'b0, imem_req}, 32'd1);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    run_en   = 1'b0;
    rstn     = 1'b0;
    #1;
    check("rw_busy", {31'b0, busy}, 32'd0);
    check("rw_req_low", {31'b0, imem_req}, 32'd0);
    check("rw_addr", imem_addr, 32'd0);
    check("rw_instr", instruction, 32'd0);
    check("rw_count", retired_count, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h00208033;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("late_rv_instr", instruction, 32'd0);
    check("late_rv_busy", {31'b0, busy}, 32'd0);
    check("late_rv_we", {31'b0, write_en}, 32'd0);
    check("late_rv_illegal", {31'b0, illegal}, 32'd0);
    check("late_rv_alu_sel", {28'b0, alu_sel}, 32'd0);
    check("late_rv_addr", imem_addr, 32'd0);
    @(negedge clk);
    check("late_rv_instr2", instruction, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
